// File: rtl/systolic_seq_ctrl.sv
// Job sequencer for an N x N output-stationary systolic array: clear, skewed operand feed, drain, capture.
// Latency start->done is K+3N cycles (1 for K=0); it has no backpressure, and abort cancels a job in CLEAR, FEED or DRAIN.
module systolic_seq_ctrl #(
    parameter int N     = 4,
    parameter int K_MAX = 16,
    parameter int KW    = $clog2(K_MAX + 1),
    parameter int AW    = $clog2(K_MAX)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [KW-1:0]   k_len,
    input  logic            abort,
    output logic            busy,
    output logic            done,
    output logic            acc_clr,
    output logic [N-1:0]    a_rd_en,
    output logic [N*AW-1:0] a_rd_addr,
    output logic [N-1:0]    b_rd_en,
    output logic [N*AW-1:0] b_rd_addr,
    output logic            res_capture
);

    localparam int TW = $clog2(K_MAX + N - 1);
    localparam int DW = $clog2(2 * N - 1);

    localparam logic [TW-1:0] T_EXTRA = TW'(N - 2);
    localparam logic [DW-1:0] D_LAST  = DW'(2 * N - 2);
    localparam logic [KW-1:0] K_SAT   = KW'(K_MAX);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t         state;
    logic [KW-1:0]  k_reg;
    logic [TW-1:0]  t;
    logic [DW-1:0]  d;
    logic [TW-1:0]  t_last;
    logic [TW-1:0]  t_nxt;

    assign t_last = TW'(k_reg) + T_EXTRA;
    assign t_nxt  = t + TW'(1);

    // Row/column i sees operand step t-i, so the wavefront enters skewed by one cycle per edge PE.
    function automatic logic [N-1:0] feed_en(input logic [TW-1:0] tv, input logic [KW-1:0] kv);
        logic [N-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) begin
            r[i] = (tv >= TW'(i)) && ((tv - TW'(i)) < TW'(kv));
        end
        return r;
    endfunction

    function automatic logic [N*AW-1:0] feed_addr(input logic [TW-1:0] tv, input logic [KW-1:0] kv);
        logic [N*AW-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) begin
            if ((tv >= TW'(i)) && ((tv - TW'(i)) < TW'(kv))) begin
                r[i*AW +: AW] = AW'(tv - TW'(i));
            end
        end
        return r;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            k_reg       <= '0;
            t           <= '0;
            d           <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            acc_clr     <= 1'b0;
            res_capture <= 1'b0;
            a_rd_en     <= '0;
            a_rd_addr   <= '0;
            b_rd_en     <= '0;
            b_rd_addr   <= '0;
        end else begin
            done        <= 1'b0;
            acc_clr     <= 1'b0;
            res_capture <= 1'b0;
            a_rd_en     <= '0;
            a_rd_addr   <= '0;
            b_rd_en     <= '0;
            b_rd_addr   <= '0;
            case (state)
                S_IDLE: begin
                    t <= '0;
                    d <= '0;
                    if (start) begin
                        busy <= 1'b1;
                        if (k_len == '0) begin
                            k_reg <= '0;
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            k_reg   <= (k_len > K_SAT) ? K_SAT : k_len;
                            acc_clr <= 1'b1;
                            state   <= S_CLEAR;
                        end
                    end
                end
                S_CLEAR: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        t         <= '0;
                        a_rd_en   <= feed_en('0, k_reg);
                        a_rd_addr <= feed_addr('0, k_reg);
                        b_rd_en   <= feed_en('0, k_reg);
                        b_rd_addr <= feed_addr('0, k_reg);
                        state     <= S_FEED;
                    end
                end
                S_FEED: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else if (t == t_last) begin
                        d     <= '0;
                        state <= S_DRAIN;
                    end else begin
                        t         <= t_nxt;
                        a_rd_en   <= feed_en(t_nxt, k_reg);
                        a_rd_addr <= feed_addr(t_nxt, k_reg);
                        b_rd_en   <= feed_en(t_nxt, k_reg);
                        b_rd_addr <= feed_addr(t_nxt, k_reg);
                    end
                end
                S_DRAIN: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else if (d == D_LAST) begin
                        done        <= 1'b1;
                        res_capture <= 1'b1;
                        state       <= S_DONE;
                    end else begin
                        d <= d + DW'(1);
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/systolic_seq_ctrl.md
Name: systolic_seq_ctrl

Overview:
- Sequencer for an N x N output-stationary systolic array of MAC/ReLU processing elements.
- On a start request it clears the PE accumulators, then drives skewed operand-fetch addresses and edge valids into the west (A rows) and north (B columns) operand buffers for K steps.
- It waits for the wavefront to reach the far corner, then pulses result capture and done.
- It sits between the host command interface and the array plus its operand buffers.

Parameters:
- N, 4, array dimension (rows = columns); N >= 2.
- K_MAX, 16, maximum inner dimension per job.
- KW, $clog2(K_MAX+1), width of k_len.
- AW, $clog2(K_MAX), operand buffer address width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset; 0 resets all state.
- start  in  1  job request; sampled only in IDLE.
- k_len  in  KW  inner dimension K; sampled with start.
- abort  in  1  synchronous job cancel.
- busy  out  1  1 whenever state != IDLE.
- done  out  1  one-cycle job-complete pulse.
- acc_clr  out  1  one-cycle accumulator clear to all PEs.
- a_rd_en  out  N  per-row A buffer read enable, also the west-edge valid_in.
- a_rd_addr  out  N*AW  per-row A address; row i at bits [i*AW +: AW].
- b_rd_en  out  N  per-column B read enable, also the north-edge valid_in.
- b_rd_addr  out  N*AW  per-column B address, packed the same way.
- res_capture  out  1  one-cycle strobe to latch all N*N PE results.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE and all counters=0. All outputs are 0: busy, done, acc_clr, a_rd_en, a_rd_addr, b_rd_en, b_rd_addr, res_capture. Reset mid-job abandons the job immediately, with no done pulse.
- All outputs are registered, or decoded from registered state only. No combinational path from inputs to outputs.
- FSM states: IDLE, CLEAR, FEED, DRAIN, DONE.
- IDLE:
  - start=1 and k_len in 1..K_MAX: latch K=k_len and go to CLEAR.
  - start=1 and k_len=0: go straight to DONE (zero-length job: no clear, no feed).
  - start=1 and k_len>K_MAX: treat K as K_MAX (saturate).
- CLEAR: acc_clr=1 for exactly 1 cycle. Clear feed counter t=0. Go to FEED.
- FEED: lasts K+N-1 cycles, with t = 0 .. K+N-2, incrementing each cycle.
  - Row i: a_rd_en[i] = (i <= t < i+K); a_rd_addr[i] = t-i when enabled, else 0.
  - Column j: the same rule with b_rd_en[j] and b_rd_addr[j].
  - After t = K+N-2, go to DRAIN.
- DRAIN: hold all enables and addresses at 0 for exactly 2N-1 cycles (pipeline propagation to PE[N-1][N-1] plus buffer read latency of 1). Then go to DONE.
- DONE: done=1 and res_capture=1 for exactly 1 cycle (both 0 for a zero-length job), then go to IDLE. busy=1 in this cycle.
- start while busy=1 is ignored and not queued. k_len is only sampled at accepted start.
- abort=1 in CLEAR, FEED or DRAIN: next state IDLE. All enables drop the next cycle; no done, no res_capture.
  - abort in DONE is ignored (done completes).
  - abort in IDLE has no effect. If abort and start are both 1 in IDLE, start wins.
- Latency, start edge to done cycle: 1 + (K+N-1) + (2N-1) + 1 cycles for K>=1; 1 cycle for K=0.
- Counters are sized to hold K_MAX+N-2 and 2N-2 without wrap. There is no wrap-around anywhere.

Test Plan:
- Reset: hold rst=0 across random start/abort activity. All outputs are 0. Release; busy stays 0 until start.
- Nominal job, N=4, k_len=3, start at cycle 0:
  - acc_clr=1 in cycle 1.
  - a_rd_en = 0001, 0011, 0111, 1110, 1100, 1000 in cycles 2-7.
  - a_rd_addr row 2 = 0, 1, 2 in cycles 4-6; b_* identical.
  - Enables all 0 in cycles 8-14.
  - done=1 and res_capture=1 in cycle 15 only; busy=1 in cycles 1-15.
- Zero/oversize k_len:
  - k_len=0: done=1 in cycle 1, acc_clr and all enables never asserted.
  - k_len=K_MAX+1 (where representable): feed lasts K_MAX+N-1 cycles; max address = K_MAX-1.
- Abort mid-FEED at t=2: next cycle state IDLE and all enables 0; no done ever. A new start immediately after runs a full correct job.
- Start while busy: pulse start with k_len=5 during FEED of a k_len=2 job. The job completes with K=2 timing and the second start is dropped (busy falls after done).
- Async reset mid-DRAIN: assert rst=0 between clock edges. Outputs go to 0 immediately with no clock edge; no done after release.
